// File: rtl/vertical_blend_fifo_if.sv
// Pixel-in / FIFO-out bus of vertical_blend_fifo.
// Default output line length width comes from IMGT_WIDTH (11 bits when not supplied).
`ifndef IMGT_WIDTH
`define IMGT_WIDTH 11
`endif

interface vertical_blend_fifo_if #(
    parameter int unsigned ADDR_W = 10
);
    logic                   din_valid;
    logic [15:0]            din1;
    logic [15:0]            din2;
    logic [7:0]             kremain;
    logic                   v_synch;
    logic [`IMGT_WIDTH-1:0] target_width;
    logic                   out_fifo_alfull;
    logic                   out_rden;
    logic [15:0]            out_data;
    logic                   out_empty;
    logic [ADDR_W:0]        out_count;
    logic                   line_done;
    logic                   overflow;

    // Upstream scaler / display side
    modport master (
        output din_valid, din1, din2, kremain, v_synch, target_width, out_rden,
        input  out_fifo_alfull, out_data, out_empty, out_count, line_done, overflow
    );

    // Blender / FIFO side
    modport slave (
        input  din_valid, din1, din2, kremain, v_synch, target_width, out_rden,
        output out_fifo_alfull, out_data, out_empty, out_count, line_done, overflow
    );
endinterface

// File: rtl/vertical_blend_fifo.sv
// Vertical line blender: per-channel RGB565 interpolation between two source lines
// weighted by kremain, feeding an on-chip output FIFO with line-level back-pressure.
// Optional feature macro: VBLEND_ROUND_EN (round-half-up instead of truncation).
`ifndef IMGT_WIDTH
`define IMGT_WIDTH 11
`endif

module vertical_blend_fifo #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned PIPE_SLACK = 8
) (
    input  logic                 clk_108m,
    input  logic                 rst,
    vertical_blend_fifo_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    // Synchronised vertical blanking
    logic vs_q1, vs_q2;

    // Pipeline registers
    logic          s1_v_q;
    rgb565_t       s1_c1_q, s1_c2_q;
    logic [8:0]    s1_w1_q, s1_w2_q;
    logic          s2_v_q;
    logic [13:0]   s2_r_q, s2_b_q;
    logic [14:0]   s2_g_q;
    logic          s3_v_q;
    logic [15:0]   s3_pix_q;

    // Line tracking
    logic [ADDR_W-1:0] lcnt_q;
    logic              line_done_q;

    // FIFO state
    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       out_data_q;
    logic              empty_q, alfull_q, ovf_q;

    // Combinational helpers
    logic        accept_c;
    rgb565_t     in1_c, in2_c;
    logic [13:0] prod_r1_c, prod_r2_c, prod_b1_c, prod_b2_c, sum_r_c, sum_b_c;
    logic [14:0] prod_g1_c, prod_g2_c, sum_g_c;
    logic        full_c, rd_fire_c, wr_fire_c, drop_c, line_last_c;
    logic [31:0] free_c, thr_c;
    logic        unused_bits_c;

    assign accept_c = bus.din_valid && !vs_q2;
    assign in1_c    = rgb565_t'(bus.din1);
    assign in2_c    = rgb565_t'(bus.din2);

    assign prod_r1_c = 14'(s1_c1_q.r) * 14'(s1_w1_q);
    assign prod_r2_c = 14'(s1_c2_q.r) * 14'(s1_w2_q);
    assign prod_g1_c = 15'(s1_c1_q.g) * 15'(s1_w1_q);
    assign prod_g2_c = 15'(s1_c2_q.g) * 15'(s1_w2_q);
    assign prod_b1_c = 14'(s1_c1_q.b) * 14'(s1_w1_q);
    assign prod_b2_c = 14'(s1_c2_q.b) * 14'(s1_w2_q);

    // Weights sum to 256, so even with the half-LSB bias no channel can exceed its maximum
`ifdef VBLEND_ROUND_EN
    assign sum_r_c = prod_r1_c + prod_r2_c + 14'd128;
    assign sum_g_c = prod_g1_c + prod_g2_c + 15'd128;
    assign sum_b_c = prod_b1_c + prod_b2_c + 14'd128;
`else
    assign sum_r_c = prod_r1_c + prod_r2_c;
    assign sum_g_c = prod_g1_c + prod_g2_c;
    assign sum_b_c = prod_b1_c + prod_b2_c;
`endif

    // Fraction bits and the always-zero top bit are discarded by the S3 shift
    assign unused_bits_c = ^{s2_r_q[13], s2_r_q[7:0], s2_g_q[14], s2_g_q[7:0],
                             s2_b_q[13], s2_b_q[7:0]};

    assign full_c      = (count_q == CNT_W'(DEPTH));
    assign rd_fire_c   = bus.out_rden && (count_q != '0);
    assign wr_fire_c   = s3_v_q && (!full_c || rd_fire_c);
    assign drop_c      = s3_v_q && full_c && !rd_fire_c;
    assign line_last_c = (bus.target_width != '0) &&
                         ((32'(lcnt_q) + 32'd1) == 32'(bus.target_width));

    // Next FIFO occupancy
    always_comb begin
        count_d = count_q;
        if (wr_fire_c && !rd_fire_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_fire_c && rd_fire_c) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    assign free_c = 32'(DEPTH) - 32'(count_d);
    assign thr_c  = 32'(bus.target_width) + 32'(PIPE_SLACK);

    // Two-flop synchroniser for v_synch
    always_ff @(posedge clk_108m or posedge rst) begin
        if (rst) begin
            vs_q1 <= 1'b0;
            vs_q2 <= 1'b0;
        end else begin
            vs_q1 <= bus.v_synch;
            vs_q2 <= vs_q1;
        end
    end

    // Three-stage blend pipeline; blanking flushes every in-flight pixel
    always_ff @(posedge clk_108m or posedge rst) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_c1_q  <= '0;
            s1_c2_q  <= '0;
            s1_w1_q  <= '0;
            s1_w2_q  <= '0;
            s2_v_q   <= 1'b0;
            s2_r_q   <= '0;
            s2_g_q   <= '0;
            s2_b_q   <= '0;
            s3_v_q   <= 1'b0;
            s3_pix_q <= '0;
        end else begin
            if (accept_c) begin
                s1_c1_q <= in1_c;
                s1_c2_q <= in2_c;
                s1_w2_q <= 9'(bus.kremain);
                s1_w1_q <= 9'd256 - 9'(bus.kremain);
            end
            if (s1_v_q) begin
                s2_r_q <= sum_r_c;
                s2_g_q <= sum_g_c;
                s2_b_q <= sum_b_c;
            end
            if (s2_v_q) begin
                s3_pix_q <= {s2_r_q[12:8], s2_g_q[13:8], s2_b_q[12:8]};
            end
            if (vs_q2) begin
                s1_v_q <= 1'b0;
                s2_v_q <= 1'b0;
                s3_v_q <= 1'b0;
            end else begin
                s1_v_q <= accept_c;
                s2_v_q <= s1_v_q;
                s3_v_q <= s2_v_q;
            end
        end
    end

    // Line counter; the done pulse coincides with the line's final FIFO write cycle
    always_ff @(posedge clk_108m or posedge rst) begin
        if (rst) begin
            lcnt_q      <= '0;
            line_done_q <= 1'b0;
        end else if (vs_q2) begin
            lcnt_q      <= '0;
            line_done_q <= 1'b0;
        end else begin
            line_done_q <= s2_v_q && line_last_c;
            if (s2_v_q) begin
                lcnt_q <= line_last_c ? '0 : lcnt_q + ADDR_W'(1);
            end
        end
    end

    // FIFO storage (no reset: contents are qualified by the pointers)
    always_ff @(posedge clk_108m) begin
        if (wr_fire_c) begin
            mem[wr_ptr_q] <= s3_pix_q;
        end
    end

    // FIFO pointers, registered read port and status flags
    always_ff @(posedge clk_108m or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            out_data_q <= '0;
            empty_q    <= 1'b1;
            alfull_q   <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (wr_fire_c) begin
                wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            end
            if (rd_fire_c) begin
                rd_ptr_q   <= rd_ptr_q + ADDR_W'(1);
                out_data_q <= mem[rd_ptr_q];
            end
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            alfull_q <= (free_c < thr_c);
            if (vs_q2) begin
                ovf_q <= 1'b0;
            end else if (drop_c) begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign bus.out_fifo_alfull = alfull_q;
    assign bus.out_data        = out_data_q;
    assign bus.out_empty       = empty_q;
    assign bus.out_count       = count_q;
    assign bus.line_done       = line_done_q;
    assign bus.overflow        = ovf_q;

endmodule

// File: tb/tb_vertical_blend_fifo.sv
// Scoreboard bench for vertical_blend_fifo: stimulus pushes expected FIFO words,
// a read monitor pops and compares every word the FIFO returns.
module tb_vertical_blend_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vertical_blend_fifo_if #(.ADDR_W(10)) vif ();

    vertical_blend_fifo #(.ADDR_W(10), .PIPE_SLACK(8)) dut (
        .clk_108m (clk),
        .rst      (rst),
        .bus      (vif)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [15:0] exp_q[$];
    int          cyc = 0;
    int          ld_count = 0;
    int          ld_cyc = -1;
    int          last_cyc = 0;
    logic        rd_pend = 1'b0;
    logic [15:0] last_read = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Capture accepted reads; data is due on the following cycle
    always @(posedge clk) rd_pend <= vif.out_rden && !vif.out_empty && !rst;

    // Read-data monitor
    always @(negedge clk) begin
        if (rd_pend) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got %0h expected no data", vif.out_data);
            end else begin
                last_read = exp_q.pop_front();
                check("rd_data", 32'(vif.out_data), 32'(last_read));
            end
        end
    end

    // line_done pulse monitor
    always @(negedge clk) begin
        if (vif.line_done) begin
            ld_count = ld_count + 1;
            ld_cyc   = cyc;
        end
    end

    // Watchdog
    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [15:0] pat(input int unsigned base, input int unsigned i);
        return 16'(base + i * 40503);
    endfunction

    task automatic drive_px(input logic [15:0] d1, input logic [15:0] d2, input logic [7:0] k,
                            input bit store, input logic [15:0] exp);
        @(negedge clk);
        vif.din_valid = 1'b1;
        vif.din1      = d1;
        vif.din2      = d2;
        vif.kremain   = k;
        last_cyc      = cyc;
        if (store) exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        vif.din_valid = 1'b0;
        vif.out_rden  = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic read_n(input int n);
        repeat (n) begin
            @(negedge clk);
            vif.out_rden = 1'b1;
        end
        @(negedge clk);
        vif.out_rden = 1'b0;
    endtask

    task automatic vsync_pulse();
        @(negedge clk);
        vif.v_synch = 1'b1;
        repeat (5) @(negedge clk);
        vif.v_synch = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Stream one line of kremain = 0 pixels, expecting din1 unchanged
    task automatic stream_line(input int n, input int unsigned base);
        for (int i = 0; i < n; i++) begin
            drive_px(pat(base, i), ~pat(base, i), 8'd0, 1'b1, pat(base, i));
        end
    endtask

    initial begin
        logic [15:0] px_p;
        vif.din_valid    = 1'b0;
        vif.din1         = '0;
        vif.din2         = '0;
        vif.kremain      = '0;
        vif.v_synch      = 1'b0;
        vif.out_rden     = 1'b0;
        vif.target_width = 800;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_alfull", 32'(vif.out_fifo_alfull), 0);
        check("rst_data",   32'(vif.out_data), 0);
        check("rst_empty",  32'(vif.out_empty), 1);
        check("rst_count",  32'(vif.out_count), 0);
        check("rst_ldone",  32'(vif.line_done), 0);
        check("rst_ovf",    32'(vif.overflow), 0);

        // kremain = 0 passes din1; out_empty falls 4 cycles after the first valid
        for (int i = 0; i < 4; i++) begin
            drive_px(16'hF800, 16'h001F, 8'd0, 1'b1, 16'hF800);
            if (i == 3) check("empty_n3", 32'(vif.out_empty), 1);
        end
        idle(1);
        check("empty_n4", 32'(vif.out_empty), 0);
        idle(4);
        check("count_4", 32'(vif.out_count), 4);
        read_n(4);
        idle(3);

        // Hand-computed blends
`ifdef VBLEND_ROUND_EN
        drive_px(16'h0000, 16'hFFFF, 8'd128, 1'b1, 16'h8410);
        drive_px(16'hF800, 16'h07E0, 8'd255, 1'b1, 16'h07E0);
`else
        drive_px(16'h0000, 16'hFFFF, 8'd128, 1'b1, 16'h7BEF);
        drive_px(16'hF800, 16'h07E0, 8'd255, 1'b1, 16'h07C0);
`endif
        drive_px(16'hFFFF, 16'h0000, 8'd64, 1'b1, 16'hBDF7);
        idle(6);
        check("count_3", 32'(vif.out_count), 3);
        read_n(3);
        idle(3);
        check("empty_after_blend", 32'(vif.out_empty), 1);

        // Full 800-pixel line
        vsync_pulse();
        ld_count = 0;
        stream_line(800, 100);
        idle(8);
        check("line_pulses", 32'(ld_count), 1);
        check("line_timing", 32'(ld_cyc), 32'(last_cyc + 3));
        check("line_count",  32'(vif.out_count), 800);
        check("line_alfull", 32'(vif.out_fifo_alfull), 1);
        read_n(800);
        idle(3);
        check("line_drained", 32'(vif.out_count), 0);
        check("line_alfull_clr", 32'(vif.out_fifo_alfull), 0);

        // Overflow: 1024 stored, the 1025th dropped
        stream_line(1024, 7);
        drive_px(16'h1234, 16'h4321, 8'd0, 1'b0, 16'h0);
        idle(8);
        check("full_count", 32'(vif.out_count), 1024);
        check("ovf_set",    32'(vif.overflow), 1);

        // Simultaneous read and write while full
        px_p = 16'hA5C3;
        drive_px(px_p, 16'h0000, 8'd0, 1'b1, px_p);
        idle(2);
        @(negedge clk);
        vif.out_rden = 1'b1;
        @(negedge clk);
        vif.out_rden = 1'b0;
        check("full_rw_count", 32'(vif.out_count), 1024);
        idle(2);

        // Blanking clears overflow but keeps contents
        @(negedge clk);
        vif.v_synch = 1'b1;
        repeat (4) @(negedge clk);
        check("vs_ovf_clr",   32'(vif.overflow), 0);
        check("vs_count_keep", 32'(vif.out_count), 1024);
        vif.v_synch = 1'b0;
        repeat (3) @(negedge clk);
        read_n(1024);
        idle(3);
        check("ovf_drained", 32'(vif.out_empty), 1);
        check("last_read_p", 32'(last_read), 32'(px_p));

        // Read while empty is ignored
        @(negedge clk);
        vif.out_rden = 1'b1;
        @(negedge clk);
        vif.out_rden = 1'b0;
        @(negedge clk);
        check("rd_empty_hold", 32'(vif.out_data), 32'(16'hA5C3));
        check("rd_empty_count", 32'(vif.out_count), 0);

        // Reset mid-line with 500 entries stored
        vsync_pulse();
        stream_line(500, 55);
        idle(6);
        check("mid_count_500", 32'(vif.out_count), 500);
        stream_line(5, 999);
        rst = 1'b1;
        #1;
        check("mid_rst_count", 32'(vif.out_count), 0);
        check("mid_rst_empty", 32'(vif.out_empty), 1);
        check("mid_rst_ldone", 32'(vif.line_done), 0);
        exp_q.delete();
        idle(2);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Following line starts clean
        ld_count = 0;
        stream_line(800, 31337);
        idle(8);
        check("post_rst_count",  32'(vif.out_count), 800);
        check("post_rst_pulses", 32'(ld_count), 1);
        check("post_rst_timing", 32'(ld_cyc), 32'(last_cyc + 3));
        read_n(800);
        idle(3);
        check("queue_drained", 32'(exp_q.size()), 0);
        check("final_empty",   32'(vif.out_empty), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vertical_blend_fifo.md
Name: vertical_blend_fifo

Overview:
- Downstream neighbour of the vertical scaler.
- Takes the two aligned source-line pixels (RGB565) and the 8-bit fractional weight Kremain, and performs per-channel linear interpolation between the lines.
- Writes blended pixels into an on-chip output FIFO; the display/output side drains it.
- Generates the out_fifo_alfull back-pressure that the scaler samples before starting each line.

Parameters:
- ADDR_W, 10, FIFO address width; depth = 2^ADDR_W = 1024 pixels.
- PIPE_SLACK, 8, extra free entries reserved beyond one line for in-flight pixels.

Ports:
- clk_108m  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- din_valid  in  1  din1/din2 valid this cycle
- din1  in  16  upper-line pixel, RGB565 {R[15:11],G[10:5],B[4:0]}
- din2  in  16  lower-line pixel, RGB565
- kremain  in  8  weight of din2 in 1/256 units; stable for a whole line
- v_synch  in  1  vertical blanking, active high
- target_width  in  `IMGT_WIDTH  output line length in pixels
- out_fifo_alfull  out  1  free space < target_width + PIPE_SLACK
- out_rden  in  1  FIFO read request
- out_data  out  16  FIFO read data, valid the cycle after an accepted out_rden
- out_empty  out  1  FIFO empty
- out_count  out  ADDR_W+1  FIFO occupancy
- line_done  out  1  one-cycle pulse when target_width pixels of a line have been written
- overflow  out  1  sticky: a write was dropped

Behaviour:
- Reset values:
  - out_fifo_alfull = 0, out_data = 0, out_empty = 1, out_count = 0, line_done = 0, overflow = 0.
  - Pipeline valids cleared; pointers = 0.
- Input timing: din1, din2 and kremain are sampled only when din_valid = 1 and the registered v_synch is low.
- Pipeline, 3 stages:
  - S1: register channels and weights, w2 = kremain, w1 = 256 - kremain (9 bits).
  - S2: per channel, sum = c1*w1 + c2*w2 (R/B 14 bits, G 15 bits).
  - S3: res = sum[..:8] (rounding per Optional Feature); pack RGB565; FIFO write.
  - Latency: din_valid in cycle N gives the FIFO write in cycle N+3; out_empty falls in N+4.
- Arithmetic limits:
  - kremain = 0 gives exactly din1.
  - Max kremain (255) gives din1/256 + din2*255/256.
  - No saturation is needed: the weights sum to 256.
- FIFO:
  - Dual-pointer RAM with ADDR_W-bit pointers that wrap modulo depth.
  - out_count is ADDR_W+1 bits.
  - Registered read: out_data updates the cycle after out_rden when not empty.
  - out_rden while empty is ignored; pointer and data are held.
  - Write while full (count = 2^ADDR_W) with no read in the same cycle: data dropped, overflow set.
  - Simultaneous read and write while full: both performed, count unchanged.
  - Simultaneous read and write while empty: the write is performed and the read is ignored.
- out_fifo_alfull:
  - Registered; asserts when (2^ADDR_W - count) < target_width + PIPE_SLACK, evaluated every cycle.
  - Rationale: the scaler commits to a whole line once started.
- Line counter (ADDR_W bits):
  - Increments on each S3 write attempt.
  - When it reaches target_width - 1 with a write attempt: line_done pulses for 1 cycle and the counter clears.
- v_synch:
  - Double-registered.
  - While high: pipeline valids cleared, line counter cleared, input ignored, overflow cleared.
  - FIFO contents are retained and reads continue.
- Reset mid-operation: everything returns to reset values immediately; FIFO is logically emptied (pointers = 0).
- target_width = 0: line_done never pulses; out_fifo_alfull depends on PIPE_SLACK only.

Optional Feature:
- Macro: VBLEND_ROUND_EN.
- Defined: S2 adds 128 before the S3 shift (round-half-up). Result never exceeds the channel maximum (31/63).
- Undefined: truncation, no constant added; one fewer adder per channel.
- Latency is unchanged either way.

Test Plan:
- Reset, kremain = 0, 4 valid pixels with din1 = 16'hF800, din2 = 16'h001F: FIFO holds 4 × 16'hF800; out_empty falls 4 cycles after the first din_valid.
- kremain = 128, din1 = 16'h0000, din2 = 16'hFFFF:
  - With VBLEND_ROUND_EN: out_data = {R16, G32, B16} = 16'h8410.
  - Without it: R15, G31, B15 = 16'h7BEF.
- target_width = 800: stream 800 valids; line_done pulses once, exactly 3 cycles after the last din_valid; out_count = 800, so free = 224 < 808 and out_fifo_alfull = 1.
- Overflow: fill 1024 entries with no reads, write 1 more → overflow = 1, count stays 1024. Then raise v_synch → overflow clears; the FIFO still reads 1024 entries in order.
- Simultaneous read/write while full: out_count stays 1024 and read order is preserved. out_rden while empty: out_data unchanged.
- Assert rst mid-line with 500 entries stored: out_count = 0, out_empty = 1, line_done = 0; the following line writes from address 0.
